// File: rtl/mod12_ctrl_pkg.sv
// Shared types and constants for the mod-12 command arbiter slice.
//   op_e    : command opcodes as carried on reqN_op
//   state_e : sequencing states of the command controller
//   MODULUS / WIDTH / STEP_W : default counter modulus, data width and
//                              step-count width
package mod12_ctrl_pkg;

  localparam int MODULUS = 12;
  localparam int WIDTH   = 4;
  localparam int STEP_W  = 4;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_STEP = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/mod12_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clock, reset       : clock and synchronous active-high reset
//   valid0_i, valid1_i : request lines
//   accept_i           : a grant was taken this cycle; remember the winner
//   grant0_o, grant1_o : one-hot (or zero) grant, combinational from valids
// After reset last_grant is 1, so requester 0 wins the first contest.
module mod12_rr_arb2 (
  input  logic clock,
  input  logic reset,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic accept_i,
  output logic grant0_o,
  output logic grant1_o
);

  logic lastGrant_q;
  logic lastGrant_d;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant0_o = valid0_i && (!valid1_i || lastGrant_q);
    grant1_o = valid1_i && (!valid0_i || !lastGrant_q);
  end

  always_comb begin
    lastGrant_d = lastGrant_q;
    if (accept_i) begin
      lastGrant_d = grant1_o;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lastGrant_q <= 1'b1;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: rtl/mod12_cmd_arbiter.sv
// Command front end sharing one mod-12 loadable up/down counter between two
// requesters. Each requester issues READ / LOAD / UP n / DOWN n over a
// valid/ready handshake; one response pulse is returned per command.
//   clock, reset                         : clock, synchronous active-high reset
//   reqN_valid/ready/op/data (N = 0, 1)  : command handshake per requester
//   rsp_valid/id/count/err               : one-cycle response
//   busy                                 : command in progress
//   cnt_load/din/up_down/resetn          : drive the external counter
//   cnt_count                            : registered count from the counter
// The counter steps on every edge unless loaded, so it is held by reloading
// its own value (cnt_din = cnt_count) in IDLE and DONE.
module mod12_cmd_arbiter #(
  parameter int MODULUS = mod12_ctrl_pkg::MODULUS,
  parameter int WIDTH   = mod12_ctrl_pkg::WIDTH,
  parameter int STEP_W  = mod12_ctrl_pkg::STEP_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_count,
  output logic             rsp_err,
  output logic             busy,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_din,
  output logic             cnt_up_down,
  output logic             cnt_resetn,
  input  logic [WIDTH-1:0] cnt_count
);

  import mod12_ctrl_pkg::*;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                id_q, id_d;
  logic                err_q, err_d;
  logic [STEP_W-1:0]   step_q, step_d;

  logic grant0;
  logic grant1;
  logic isIdle;
  logic accept;

  assign isIdle = (state_q == ST_IDLE);
  assign accept = isIdle && (grant0 || grant1);

  mod12_rr_arb2 u_arb (
    .clock    (clock),
    .reset    (reset),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .accept_i (accept),
    .grant0_o (grant0),
    .grant1_o (grant1)
  );

  // Next-state logic. Commands are latched on the handshake; out-of-range
  // LOADs and zero-length steps go straight to DONE without touching the
  // counter.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    id_d    = id_q;
    err_d   = err_q;
    step_d  = step_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d   = grant1;
          op_d   = grant1 ? op_e'(req1_op) : op_e'(req0_op);
          data_d = grant1 ? req1_data : req0_data;
          err_d  = 1'b0;
          step_d = '0;
          case (op_d)
            OP_LOAD: begin
              if (data_d > WIDTH'(MODULUS - 1)) begin
                err_d   = 1'b1;
                state_d = ST_DONE;
              end else begin
                state_d = ST_LOAD;
              end
            end
            OP_UP, OP_DOWN: begin
              if (data_d == '0) begin
                op_d    = OP_READ;
                state_d = ST_DONE;
              end else begin
                step_d  = STEP_W'(data_d);
                state_d = ST_STEP;
              end
            end
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_LOAD: state_d = ST_DONE;
      // Leaving on step_q == 1 makes the counter step exactly n times.
      ST_STEP: begin
        step_d = step_q - STEP_W'(1);
        if (step_q == STEP_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      data_q  <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      id_q    <= id_d;
      err_q   <= err_d;
      step_q  <= step_d;
    end
  end

  // Outputs are decoded from the state register; the counter is held with
  // its own value except while loading or stepping.
  always_comb begin
    req0_ready  = isIdle && grant0;
    req1_ready  = isIdle && grant1;
    busy        = !isIdle;
    rsp_valid   = 1'b0;
    rsp_id      = 1'b0;
    rsp_count   = '0;
    rsp_err     = 1'b0;
    cnt_load    = 1'b1;
    cnt_din     = cnt_count;
    cnt_up_down = 1'b0;
    cnt_resetn  = !reset;
    case (state_q)
      ST_LOAD: cnt_din = data_q;
      ST_STEP: begin
        cnt_load    = 1'b0;
        cnt_up_down = (op_q == OP_UP);
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_count = cnt_count;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mod12_cmd_arbiter.sv
// Self-checking bench for mod12_cmd_arbiter. A behavioural mod-12 counter is
// attached to the cnt_* pins; expected responses are computed from a
// reference count when each command is accepted and queued, then compared
// when the response pulse appears.
module tb_mod12_cmd_arbiter;

   typedef struct {
      int id;
      int count;
      int err;
      int cycle;
   } rsp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req0Valid = 1'b0;
   logic       req0Ready;
   logic [1:0] req0Op = 2'b00;
   logic [3:0] req0Data = 4'd0;
   logic       req1Valid = 1'b0;
   logic       req1Ready;
   logic [1:0] req1Op = 2'b00;
   logic [3:0] req1Data = 4'd0;
   logic       rspValid;
   logic       rspId;
   logic [3:0] rspCount;
   logic       rspErr;
   logic       busy;
   logic       cntLoad;
   logic [3:0] cntDin;
   logic       cntUpDown;
   logic       cntResetn;
   logic [3:0] cntCount;

   int   checkCount = 0;
   int   errorCount = 0;
   int   cycleCount = 0;
   int   refCount = 0;
   int   rspSeen = 0;
   int   badLoadSeen = 0;
   rsp_t expQ[$];
   int   grantOrder[$];

   mod12_cmd_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .req0_valid  (req0Valid),
      .req0_ready  (req0Ready),
      .req0_op     (req0Op),
      .req0_data   (req0Data),
      .req1_valid  (req1Valid),
      .req1_ready  (req1Ready),
      .req1_op     (req1Op),
      .req1_data   (req1Data),
      .rsp_valid   (rspValid),
      .rsp_id      (rspId),
      .rsp_count   (rspCount),
      .rsp_err     (rspErr),
      .busy        (busy),
      .cnt_load    (cntLoad),
      .cnt_din     (cntDin),
      .cnt_up_down (cntUpDown),
      .cnt_resetn  (cntResetn),
      .cnt_count   (cntCount)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycleCount <= cycleCount + 1;

   // Behavioural mod-12 counter: steps on every edge unless loaded.
   always @(posedge clock) begin
      if (!cntResetn)          cntCount <= 4'd0;
      else if (cntLoad)        cntCount <= cntDin;
      else if (cntUpDown)      cntCount <= (cntCount == 4'd11) ? 4'd0 : cntCount + 4'd1;
      else                     cntCount <= (cntCount == 4'd0) ? 4'd11 : cntCount - 4'd1;
   end

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Response scoreboard and illegal-load watch.
   always @(negedge clock) begin
      rsp_t e;
      if (cntLoad === 1'b1 && cntDin === 4'd13) badLoadSeen++;
      if (rspValid === 1'b1) begin
         rspSeen++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected rsp", 1, 0);
         end else begin
            e = expQ.pop_front();
            checkOutput("rsp id", int'(rspId), e.id);
            checkOutput("rsp count", int'(rspCount), e.count);
            checkOutput("rsp err", int'(rspErr), e.err);
            checkOutput("rsp cycle", cycleCount, e.cycle);
         end
      end
   end

   // Drive one command, wait (bounded) for acceptance and queue the
   // expected response computed from the reference count.
   task automatic applyStimulus(input int id, input int op, input int data);
      int   waited;
      int   lat;
      rsp_t e;
      @(negedge clock);
      if (id == 0) begin
         req0Valid = 1'b1; req0Op = 2'(op); req0Data = 4'(data);
      end else begin
         req1Valid = 1'b1; req1Op = 2'(op); req1Data = 4'(data);
      end
      #1;
      waited = 0;
      while (!((id == 0) ? req0Ready : req1Ready) && waited < 200) begin
         @(negedge clock);
         #1;
         waited++;
      end
      if (waited >= 200) begin
         checkOutput("ready timeout", 0, 1);
         if (id == 0) req0Valid = 1'b0; else req1Valid = 1'b0;
         return;
      end
      e.id  = id;
      e.err = 0;
      lat   = 1;
      case (op)
         1: begin
            if (data <= 11) begin refCount = data; lat = 2; end
            else e.err = 1;
         end
         2: if (data != 0) begin refCount = (refCount + data) % 12; lat = data + 1; end
         3: if (data != 0) begin refCount = (refCount + 24 - data) % 12; lat = data + 1; end
         default: ;
      endcase
      e.count = refCount;
      e.cycle = cycleCount + lat;
      expQ.push_back(e);
      grantOrder.push_back(id);
      @(posedge clock);
      #1;
      if (id == 0) req0Valid = 1'b0; else req1Valid = 1'b0;
   endtask

   task automatic waitDrain();
      int waited = 0;
      while (expQ.size() != 0 && waited < 100) begin
         @(negedge clock);
         waited++;
      end
      if (expQ.size() != 0) checkOutput("drain timeout", expQ.size(), 0);
      @(negedge clock);
   endtask

   task automatic doReset();
      @(negedge clock);
      reset = 1'b1;
      expQ.delete();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      refCount = 0;
   endtask

   initial begin
      int seenBefore;
      int expOrder[7] = '{0, 1, 0, 1, 0, 1, 0};

      // Reset values
      repeat (2) @(negedge clock);
      checkOutput("reset rsp_valid", int'(rspValid), 0);
      checkOutput("reset rsp_id", int'(rspId), 0);
      checkOutput("reset rsp_count", int'(rspCount), 0);
      checkOutput("reset rsp_err", int'(rspErr), 0);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset cnt_resetn", int'(cntResetn), 0);
      checkOutput("reset count", int'(cntCount), 0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("cnt_resetn after reset", int'(cntResetn), 1);
      checkOutput("idle ready0", int'(req0Ready), 0);

      // LOAD, wrap-around steps, READ
      applyStimulus(0, 1, 7);
      waitDrain();
      repeat (3) @(negedge clock);
      checkOutput("hold after load", int'(cntCount), 7);
      applyStimulus(1, 2, 6);
      checkOutput("busy during step", int'(busy), 1);
      applyStimulus(0, 3, 3);
      applyStimulus(0, 0, 0);
      applyStimulus(1, 1, 13);
      applyStimulus(0, 2, 0);
      applyStimulus(1, 3, 15);
      applyStimulus(0, 1, 11);
      applyStimulus(1, 2, 1);
      applyStimulus(0, 1, 12);
      waitDrain();
      checkOutput("count after sequence", int'(cntCount), refCount);

      // Simultaneous requests after reset alternate the grant
      doReset();
      grantOrder.delete();
      fork
         applyStimulus(0, 1, 3);
         applyStimulus(1, 2, 2);
      join
      fork
         applyStimulus(0, 0, 0);
         applyStimulus(1, 3, 4);
      join
      applyStimulus(0, 0, 0);
      fork
         applyStimulus(1, 2, 5);
         applyStimulus(0, 3, 1);
      join
      waitDrain();
      checkOutput("grant count", grantOrder.size(), 7);
      for (int i = 0; i < 7; i++) begin
         if (i < grantOrder.size()) checkOutput($sformatf("grant order %0d", i), grantOrder[i], expOrder[i]);
      end

      // Reset in the middle of UP 9 aborts the command silently
      applyStimulus(1, 2, 9);
      repeat (3) @(negedge clock);
      seenBefore = rspSeen;
      doReset();
      @(negedge clock);
      checkOutput("abort busy", int'(busy), 0);
      checkOutput("abort count", int'(cntCount), 0);
      checkOutput("abort no rsp", rspSeen, seenBefore);
      grantOrder.delete();
      fork
         applyStimulus(1, 1, 5);
         applyStimulus(0, 2, 9);
      join
      waitDrain();
      if (grantOrder.size() > 0) checkOutput("first grant after reset", grantOrder[0], 0);
      else checkOutput("first grant after reset", -1, 0);
      checkOutput("final count", int'(cntCount), refCount);

      checkOutput("scoreboard empty", expQ.size(), 0);
      checkOutput("illegal load driven", badLoadSeen, 0);
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/mod12_cmd_arbiter.md
Name: mod12_cmd_arbiter

Overview:
- Shares one mod-12 loadable up/down counter between two command requesters.
- Each requester issues LOAD / COUNT_UP n / COUNT_DOWN n / READ commands over a valid/ready handshake. The block arbitrates round-robin and sequences the counter's load, din and up_down controls cycle by cycle.
- It returns a single response (final count, requester id, error flag) per command.
- It sits between the requesters and the counter; the counter's own pins (load, din, up_down, resetn, count) connect directly to the cnt_* ports.

Parameters:
- MODULUS, 12, counter modulus; legal count values are 0..MODULUS-1.
- WIDTH, 4, width of count and data.
- STEP_W, 4, width of the step-count field for UP/DOWN commands.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_op  in  2  00=READ, 01=LOAD, 10=UP, 11=DOWN.
- req0_data  in  WIDTH  LOAD value, or step count n for UP/DOWN.
- req1_valid, req1_ready, req1_op, req1_data  same widths and meaning, requester 1.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester that owns the response.
- rsp_count  out  WIDTH  counter value after the command.
- rsp_err  out  1  command rejected.
- busy  out  1  high in every state except IDLE.
- cnt_load  out  1  to counter load.
- cnt_din  out  WIDTH  to counter din.
- cnt_up_down  out  1  to counter up_down; 1 = up.
- cnt_resetn  out  1  to counter resetn; equals !reset, combinational.
- cnt_count  in  WIDTH  from counter count; registered in the counter.

Behaviour:
- Counter model: the counter steps on every posedge unless load=1. The block therefore holds the counter by driving cnt_load=1 and cnt_din=cnt_count in IDLE and DONE.
- FSM states: IDLE, LOAD, STEP, DONE. Outputs are decoded from the state register; the only combinational path is cnt_din=cnt_count while holding.
- Reset values: state=IDLE, rsp_valid=0, rsp_id=0, rsp_count=0, rsp_err=0, busy=0, reqN_ready=0, step counter=0, last_grant=1 (so requester 0 wins first). cnt_resetn=0 while reset is high, which also clears the counter to 0.
- IDLE arbitration:
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester that is not last_grant is granted.
  - reqN_ready=1 combinationally for the granted requester only, in IDLE only.
  - On the handshake, latch op, data and id, and update last_grant.
- Transitions out of IDLE, on handshake:
  - LOAD with data <= MODULUS-1 -> LOAD.
  - LOAD with data > MODULUS-1 -> DONE with err=1; the counter is not loaded.
  - UP/DOWN with n > 0 -> STEP, step counter = n.
  - UP/DOWN with n = 0 -> DONE, treated as READ.
  - READ -> DONE.
- LOAD state: one cycle, cnt_load=1, cnt_din=latched data -> DONE.
- STEP state: cnt_load=0, cnt_up_down = (op==UP). Decrement the step counter each cycle; on the cycle it equals 1 -> DONE. The counter therefore steps exactly n times.
- DONE state: one cycle. Hold the counter; rsp_valid=1, rsp_count=cnt_count, rsp_id=latched id, rsp_err set as above -> IDLE. No response backpressure.
- Latency from a handshake at cycle T:
  - READ: rsp at T+1.
  - LOAD: rsp at T+2.
  - UP/DOWN n: rsp at T+n+1.
- Wrap-around is performed by the counter: UP from 11 -> 0, DOWN from 0 -> 11. The final value is (start ± n) mod 12.
- No new command is accepted while busy; ready stays 0 and requester valid must be held.
- Reset mid-operation: the command is aborted, no response is issued, state=IDLE, counter=0, last_grant=1.

Decomposition:
- Package mod12_ctrl_pkg:
  - op_e enum: READ, LOAD, UP, DOWN.
  - state_e enum: IDLE, LOAD, STEP, DONE.
  - Constants MODULUS=12 and WIDTH=4.
- One natural sub-module, mod12_rr_arb2: a two-requester round-robin arbiter holding last_grant, with grant outputs and an update-on-accept input.

Test Plan:
- Reset, then req0 LOAD 7 -> req0_ready pulse at T, rsp at T+2 with id=0, count=7, err=0; counter holds 7 afterwards.
- From 7, req1 UP 6 -> counter steps 8,9,10,11,0,1; rsp at T+7 with id=1, count=1.
- From 1, req0 DOWN 3 -> 0,11,10; rsp count=10; then READ -> rsp at T+1 with count=10.
- LOAD 13 -> rsp err=1, count unchanged (10), cnt_load never driven with 13.
- Both valid in the same cycle after reset -> req0 granted first, req1 granted at the next IDLE. Repeat the simultaneous request -> the grant alternates.
- Assert reset mid-STEP of UP 9 -> no rsp_valid, busy=0 and counter=0 the cycle after reset deasserts; the next command proceeds normally.
